bsg_tline_channel_mapper: RTL and testbench
===========================================

Name: bsg_tline_channel_mapper

Overview:
Parametrised, runtime-programmable permutation stage between the per-channel source-synchronous IO receivers and the core-side logical channels. It replaces fixed, hard-wired channel swizzles. It generalises channel count and width, adds a shadow/commit configuration path, and adds a training mode that learns the physical-to-logical lane map from a tagged pattern. Data passes through with one-cycle registered latency.

Parameters:
channels_p, 4, number of channels; power of 2, 2..16.
width_p, 8, data bits per channel; must satisfy width_p >= lg(channels_p)+4.
default_map_p, identity ({3,2,1,0} packed for 4 channels), reset permutation; field j = physical source of logical channel j, each field lg(channels_p) bits wide.
magic_p, 4'hA, training tag carried in data[width_p-1 -: 4].

Ports:
clk_i  in  1  block clock.
reset_n_i  in  1  asynchronous reset, active low.
phys_v_i  in  channels_p  per-physical-channel valid.
phys_data_i  in  channels_p*width_p  physical data; channel k occupies [k*width_p +: width_p].
log_v_o  out  channels_p  per-logical-channel valid, registered.
log_data_o  out  channels_p*width_p  logical data, registered.
cfg_v_i  in  1  write shadow entry.
cfg_addr_i  in  lg(channels_p)  logical channel index.
cfg_data_i  in  lg(channels_p)  physical source index.
cfg_commit_i  in  1  copy shadow into active map.
train_i  in  1  level; high requests training.
train_done_o  out  1  training completed, map consistent.
train_err_o  out  1  training failed.
active_map_o  out  channels_p*lg(channels_p)  current active map.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert via flops on clk_i):
  - active and shadow maps = default_map_p.
  - log_v_o=0, log_data_o=0.
  - state=IDLE; train_done_o=0; train_err_o=0; found vector=0.
- Datapath: each cycle, log_v_o[j] <= phys_v_i[map[j]] and log_data_o[j] <= phys_data_i[map[j]]. Latency is exactly 1 cycle.
- Outputs are forced to log_v_o=0 in these cases:
  - the cycle after a commit is accepted (one-cycle blackout);
  - any cycle while state=TRAIN.
- Config writes:
  - cfg_v_i writes shadow[cfg_addr_i]=cfg_data_i. Writes are accepted in IDLE/DONE/ERR and ignored in TRAIN.
  - cfg_commit_i copies the shadow into the active map at the clock edge. The new map takes effect on the next datapath cycle.
  - If cfg_v_i and cfg_commit_i are asserted in the same cycle, the commit includes that write.
  - The map is not checked for being a permutation; duplicate fields fan one physical lane out to several logical channels.
- Training FSM, states IDLE, TRAIN, DONE, ERR:
  - IDLE: train_i=1 -> TRAIN, clears found, train_done_o, train_err_o.
  - TRAIN: for each physical k with phys_v_i[k] and tag==magic_p, let id = low lg(channels_p) bits.
    - If found[id]=0: shadow[id]=k and found[id]=1.
    - If found[id]=1 with a different k: -> ERR.
    - If found[id]=1 with the same k: no effect.
  - Within one cycle, tagged beats are processed lowest k first. Two lanes carrying the same id in the same cycle -> ERR.
  - Bits between the tag and the id must be 0, otherwise the beat is ignored.
  - Once found is all ones: shadow is auto-committed to active at the same edge, -> DONE, train_done_o=1.
  - train_i deasserted while in TRAIN -> IDLE; shadow keeps partial updates and active is unchanged.
  - DONE: holds train_done_o=1. train_i falling -> IDLE and clears train_done_o.
  - ERR: holds train_err_o=1. Active is unchanged. train_i falling -> IDLE and clears train_err_o.
  - cfg_commit_i is ignored in TRAIN.
- Reset mid-training returns everything to reset values immediately.

Test Plan:
- Reset, then 4 channels with lane k data=8'h10+k, valid on all -> next cycle log_data_o[j]=8'h10+j, log_v_o=4'hF; during reset log_v_o=0.
- Write shadow {0->2, 1->3, 2->0, 3->1}, commit -> blackout cycle with log_v_o=0. The following cycle log_data_o[0]=8'h12, [1]=8'h13, [2]=8'h10, [3]=8'h11; active_map_o reflects the new map.
- cfg_v_i with addr 1, data 0 in the same cycle as commit -> active[1]=0 and logical 1 duplicates physical 0.
- Train with phys lanes sending 8'hA1, 8'hA3, 8'hA0, 8'hA2 (lane 0..3) -> within 2 cycles train_done_o=1 and active map = {log0<-phys2, log1<-phys0, log2<-phys3, log3<-phys1}; log_v_o=0 throughout TRAIN.
- Train with lanes 0 and 2 both sending 8'hA1 in the same cycle -> train_err_o=1, active map unchanged. train_i low -> IDLE with both flags 0.
- Assert reset_n_i low mid-TRAIN after two ids found -> asynchronously log_v_o=0, flags 0, active_map_o=default_map_p.

Source files
------------

// File: rtl/bsg_tline_channel_mapper.sv
// bsg_tline_channel_mapper
// Runtime-programmable permutation between physical receive lanes and
// core-side logical channels, with a shadow/commit map and a training mode
// that learns the lane map from tagged beats.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   phys_v_i, phys_data_i     per-physical-lane valid and data
//   log_v_o, log_data_o       per-logical-channel valid and data (registered)
//   cfg_v_i, cfg_addr_i,
//   cfg_data_i, cfg_commit_i  shadow map write and commit to active
//   train_i                   level request for training
//   train_done_o, train_err_o training status flags (registered)
//   active_map_o              current active map, field j = source of logical j

package bsg_tline_channel_mapper_pkg;

   // Packed identity map, field j = j, each field lg bits wide.
   function automatic logic [63:0] identity_map(int unsigned channels, int unsigned lg);
      logic [63:0] m;
      m = '0;
      for (int unsigned j = 0; j < channels; j++) begin
         m = m | (64'(j) << (j * lg));
      end
      return m;
   endfunction

endpackage

module bsg_tline_channel_mapper
  #(parameter int unsigned channels_p = 4,
    parameter int unsigned width_p    = 8,
    parameter logic [channels_p*$clog2(channels_p)-1:0] default_map_p =
       (channels_p*$clog2(channels_p))'(
          bsg_tline_channel_mapper_pkg::identity_map(channels_p, $clog2(channels_p))),
    parameter logic [3:0] magic_p = 4'hA)
   (input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [channels_p-1:0]                    phys_v_i,
    input  logic [channels_p*width_p-1:0]            phys_data_i,
    output logic [channels_p-1:0]                    log_v_o,
    output logic [channels_p*width_p-1:0]            log_data_o,
    input  logic                                     cfg_v_i,
    input  logic [$clog2(channels_p)-1:0]            cfg_addr_i,
    input  logic [$clog2(channels_p)-1:0]            cfg_data_i,
    input  logic                                     cfg_commit_i,
    input  logic                                     train_i,
    output logic                                     train_done_o,
    output logic                                     train_err_o,
    output logic [channels_p*$clog2(channels_p)-1:0] active_map_o);

   localparam int unsigned lg_lp    = $clog2(channels_p);
   localparam int unsigned low_w_lp = width_p - 4;   // bits below the tag

   typedef enum logic [1:0] {IDLE, TRAIN, DONE, ERR} state_e;

   state_e                   state_r, state_n;
   logic [lg_lp-1:0]         active_r [channels_p];
   logic [lg_lp-1:0]         active_n [channels_p];
   logic [lg_lp-1:0]         shadow_r [channels_p];
   logic [lg_lp-1:0]         shadow_n [channels_p];
   logic [channels_p-1:0]    found_r, found_n;
   logic [channels_p-1:0]    log_v_n;
   logic [channels_p*width_p-1:0] log_data_n;
   logic                     done_n, err_n;
   logic [width_p-1:0]       phys_arr [channels_p];

   // Next-state, map update and datapath selection.
   always_comb begin
      logic                commit;
      logic                bad;
      logic [width_p-1:0]  beat;
      logic [low_w_lp-1:0] low;
      logic [lg_lp-1:0]    id;

      state_n  = state_r;
      active_n = active_r;
      shadow_n = shadow_r;
      found_n  = found_r;
      done_n   = train_done_o;
      err_n    = train_err_o;
      commit   = 1'b0;
      bad      = 1'b0;
      beat     = '0;
      low      = '0;
      id       = '0;

      for (int unsigned k = 0; k < channels_p; k++) begin
         phys_arr[k] = phys_data_i[k*width_p +: width_p];
      end

      // Host configuration is frozen while training owns the shadow map.
      if (state_r != TRAIN) begin
         if (cfg_v_i) shadow_n[cfg_addr_i] = cfg_data_i;
         commit = cfg_commit_i;
      end

      unique case (state_r)
         IDLE: begin
            if (train_i) begin
               state_n = TRAIN;
               found_n = '0;
               done_n  = 1'b0;
               err_n   = 1'b0;
            end
         end
         TRAIN: begin
            if (!train_i) begin
               state_n = IDLE;
            end else begin
               // Lowest lane first, so a repeated id on a higher lane errors.
               for (int unsigned k = 0; k < channels_p; k++) begin
                  beat = phys_arr[k];
                  low  = beat[low_w_lp-1:0];
                  id   = beat[lg_lp-1:0];
                  if (phys_v_i[k] && (beat[width_p-1 -: 4] == magic_p)
                      && ((low >> lg_lp) == '0)) begin
                     if (!found_n[id]) begin
                        shadow_n[id] = lg_lp'(k);
                        found_n[id]  = 1'b1;
                     end else if (shadow_n[id] != lg_lp'(k)) begin
                        bad = 1'b1;
                     end
                  end
               end
               if (bad) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else if (&found_n) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  commit  = 1'b1;
               end
            end
         end
         DONE: begin
            if (!train_i) begin
               state_n = IDLE;
               done_n  = 1'b0;
            end
         end
         ERR: begin
            if (!train_i) begin
               state_n = IDLE;
               err_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase

      if (commit) active_n = shadow_n;

      // Datapath uses the map in force this cycle; a commit blanks one cycle.
      for (int unsigned j = 0; j < channels_p; j++) begin
         log_v_n[j] = phys_v_i[active_r[j]] && !commit && (state_n != TRAIN);
         log_data_n[j*width_p +: width_p] = phys_arr[active_r[j]];
      end
   end

   // All state.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r      <= IDLE;
         found_r      <= '0;
         train_done_o <= 1'b0;
         train_err_o  <= 1'b0;
         log_v_o      <= '0;
         log_data_o   <= '0;
         for (int unsigned j = 0; j < channels_p; j++) begin
            active_r[j] <= default_map_p[j*lg_lp +: lg_lp];
            shadow_r[j] <= default_map_p[j*lg_lp +: lg_lp];
         end
      end else begin
         state_r      <= state_n;
         found_r      <= found_n;
         train_done_o <= done_n;
         train_err_o  <= err_n;
         log_v_o      <= log_v_n;
         log_data_o   <= log_data_n;
         active_r     <= active_n;
         shadow_r     <= shadow_n;
      end
   end

   // Flatten the active map for observation.
   always_comb begin
      for (int unsigned j = 0; j < channels_p; j++) begin
         active_map_o[j*lg_lp +: lg_lp] = active_r[j];
      end
   end

endmodule

// File: tb/tb_bsg_tline_channel_mapper.sv
// Self-checking bench for bsg_tline_channel_mapper (4 channels x 8 bits):
// directed scenarios followed by randomized traffic, config and training,
// all compared against a behavioural model kept in the bench.
module tb_bsg_tline_channel_mapper;

   localparam int unsigned C  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned LG = 2;

   localparam int ST_IDLE = 0;
   localparam int ST_TRN  = 1;
   localparam int ST_DONE = 2;
   localparam int ST_ERR  = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [C-1:0]     phys_v;
   logic [C*W-1:0]   phys_data;
   logic [C-1:0]     log_v;
   logic [C*W-1:0]   log_data;
   logic             cfg_v;
   logic [LG-1:0]    cfg_addr;
   logic [LG-1:0]    cfg_data;
   logic             cfg_commit;
   logic             train;
   logic             train_done;
   logic             train_err;
   logic [C*LG-1:0]  active_map;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           m_act [C];
   int           m_sh  [C];
   bit           m_found [C];
   int           m_st;
   bit           m_done, m_err;
   logic [C-1:0]   e_v;
   logic [C*W-1:0] e_data;

   bsg_tline_channel_mapper dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .phys_v_i     (phys_v),
      .phys_data_i  (phys_data),
      .log_v_o      (log_v),
      .log_data_o   (log_data),
      .cfg_v_i      (cfg_v),
      .cfg_addr_i   (cfg_addr),
      .cfg_data_i   (cfg_data),
      .cfg_commit_i (cfg_commit),
      .train_i      (train),
      .train_done_o (train_done),
      .train_err_o  (train_err),
      .active_map_o (active_map)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [C*LG-1:0] model_map();
      logic [C*LG-1:0] r;
      for (int j = 0; j < C; j++) r[j*LG +: LG] = LG'(m_act[j]);
      return r;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < C; j++) begin
         m_act[j]   = j;
         m_sh[j]    = j;
         m_found[j] = 1'b0;
      end
      m_st   = ST_IDLE;
      m_done = 1'b0;
      m_err  = 1'b0;
      e_v    = '0;
      e_data = '0;
   endtask

   // One clock of behaviour, from the current inputs.
   task automatic model_step();
      int old_act [C];
      int nst;
      bit commit;
      bit bad;
      bit all;
      int b, id;
      old_act = m_act;
      nst     = m_st;
      commit  = 1'b0;
      bad     = 1'b0;
      if (m_st != ST_TRN) begin
         if (cfg_v) m_sh[int'(cfg_addr)] = int'(cfg_data);
         if (cfg_commit) commit = 1'b1;
      end
      case (m_st)
         ST_IDLE: if (train) begin
            nst = ST_TRN;
            for (int j = 0; j < C; j++) m_found[j] = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
         end
         ST_TRN: if (!train) nst = ST_IDLE;
         else begin
            for (int k = 0; k < C; k++) begin
               b = int'(phys_data[k*W +: W]);
               if (phys_v[k] && (b / 16) == 10 && ((b / 4) % 4) == 0) begin
                  id = b % 4;
                  if (!m_found[id]) begin
                     m_sh[id]    = k;
                     m_found[id] = 1'b1;
                  end else if (m_sh[id] != k) bad = 1'b1;
               end
            end
            all = 1'b1;
            for (int j = 0; j < C; j++) if (!m_found[j]) all = 1'b0;
            if (bad) begin
               nst   = ST_ERR;
               m_err = 1'b1;
            end else if (all) begin
               nst    = ST_DONE;
               m_done = 1'b1;
               commit = 1'b1;
            end
         end
         ST_DONE: if (!train) begin nst = ST_IDLE; m_done = 1'b0; end
         default: if (!train) begin nst = ST_IDLE; m_err = 1'b0; end
      endcase
      for (int j = 0; j < C; j++) begin
         e_data[j*W +: W] = phys_data[old_act[j]*W +: W];
         e_v[j] = phys_v[old_act[j]] && !commit && (nst != ST_TRN);
      end
      if (commit) m_act = m_sh;
      m_st = nst;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".log_v"},    32'(log_v),      32'(e_v));
      chk({tag, ".log_data"}, 32'(log_data),   32'(e_data));
      chk({tag, ".done"},     32'(train_done), 32'(m_done));
      chk({tag, ".err"},      32'(train_err),  32'(m_err));
      chk({tag, ".map"},      32'(active_map), 32'(model_map()));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int perm [C];
      int t, r;
      reset_n    = 1'b0;
      phys_v     = '0;
      phys_data  = '0;
      cfg_v      = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      cfg_commit = 1'b0;
      train      = 1'b0;
      model_reset();

      // Reset state, with live traffic applied during reset
      phys_v    = 4'hF;
      phys_data = 32'h13121110;
      @(posedge clk); #1;
      chk("reset.log_v", 32'(log_v), 32'h0);
      chk("reset.map", 32'(active_map), 32'hE4);
      chk("reset.flags", 32'({train_done, train_err}), 32'h0);
      reset_n = 1'b1;

      // Identity pass-through
      tick("ident");
      chk("ident.data", 32'(log_data), 32'h13121110);
      chk("ident.v", 32'(log_v), 32'hF);

      // Program permutation then commit
      cfg_v = 1'b1;
      cfg_addr = 2'd0; cfg_data = 2'd2; tick("wr0");
      cfg_addr = 2'd1; cfg_data = 2'd3; tick("wr1");
      cfg_addr = 2'd2; cfg_data = 2'd0; tick("wr2");
      cfg_addr = 2'd3; cfg_data = 2'd1; tick("wr3");
      cfg_v = 1'b0;
      cfg_commit = 1'b1; tick("commit");
      chk("blackout.v", 32'(log_v), 32'h0);
      cfg_commit = 1'b0; tick("perm");
      chk("perm.data", 32'(log_data), 32'h11101312);
      chk("perm.map", 32'(active_map), 32'h4E);

      // Write and commit in the same cycle
      cfg_v = 1'b1; cfg_addr = 2'd1; cfg_data = 2'd0; cfg_commit = 1'b1;
      tick("wrcommit");
      cfg_v = 1'b0; cfg_commit = 1'b0;
      tick("dup");
      chk("dup.map", 32'(active_map), 32'h42);
      chk("dup.data", 32'(log_data), 32'h11101012);

      // Successful training
      phys_data = 32'hA2A0A3A1;
      train = 1'b1; tick("train.enter");
      chk("train.v", 32'(log_v), 32'h0);
      tick("train.done");
      chk("train.done_flag", 32'(train_done), 32'h1);
      chk("train.map", 32'(active_map), 32'h72);
      train = 1'b0; tick("train.exit");
      chk("train.exit_flag", 32'(train_done), 32'h0);

      // Duplicate id on two lanes in one cycle
      phys_data = 32'h00A100A1;
      train = 1'b1; tick("dupid.enter");
      tick("dupid.err");
      chk("dupid.err_flag", 32'(train_err), 32'h1);
      chk("dupid.map", 32'(active_map), 32'h72);
      train = 1'b0; tick("dupid.exit");
      chk("dupid.flags", 32'({train_done, train_err}), 32'h0);

      // Reset during training with two ids found
      phys_data = 32'hA1005A00 | 32'h0000A000;
      phys_data = 32'hA1000000 | 32'h0000A000 | 32'h00000055;
      train = 1'b1; tick("rst.enter");
      tick("rst.partial");
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst.log_v", 32'(log_v), 32'h0);
      chk("rst.flags", 32'({train_done, train_err}), 32'h0);
      chk("rst.map", 32'(active_map), 32'hE4);
      train = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick("rst.after");

      // Randomized traffic, configuration and training
      for (int i = 0; i < C; i++) perm[i] = i;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) == 0) train = ~train;
         if ($urandom_range(0, 3) == 0) begin
            for (int i = C - 1; i > 0; i--) begin
               r = int'($urandom_range(0, i));
               t = perm[i]; perm[i] = perm[r]; perm[r] = t;
            end
         end
         phys_v = 4'($urandom);
         for (int k = 0; k < C; k++) begin
            case ($urandom_range(0, 3))
               0:       phys_data[k*W +: W] = 8'($urandom);
               1:       phys_data[k*W +: W] = 8'(8'hA0 | $urandom_range(0, 15));
               default: phys_data[k*W +: W] = 8'(8'hA0 | perm[k]);
            endcase
         end
         cfg_v      = ($urandom_range(0, 3) == 0);
         cfg_addr   = 2'($urandom_range(0, 3));
         cfg_data   = 2'($urandom_range(0, 3));
         cfg_commit = ($urandom_range(0, 9) == 0);
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
